// File: rtl/valve_sequencer_if.sv
// Mode request / tank interlock inputs and valve, pump and status outputs of the valve sequencer.
interface valve_sequencer_if;
    logic [1:0] mode;
    logic       tank_low;
    logic       valve_asp;
    logic       valve_got;
    logic       pump;
    logic       busy;
    logic       err;
    logic [1:0] seq_state;

    modport master (
        output mode, tank_low,
        input  valve_asp, valve_got, pump, busy, err, seq_state
    );

    modport slave (
        input  mode, tank_low,
        output valve_asp, valve_got, pump, busy, err, seq_state
    );
endinterface

// File: rtl/valve_sequencer.sv
// Actuator stage: drives sprinkler/drip valves and pump with break-before-make dead time,
// a maximum-run limit followed by a forced rest, and a reservoir-low interlock.
module valve_sequencer #(
    parameter int unsigned DEAD_CYCLES = 4,
    parameter int unsigned MAX_ON      = 200,
    parameter int unsigned REST_CYCLES = 50,
    parameter int unsigned CW          = 8
) (
    input  logic              CLK,
    input  logic              reset,
    valve_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DEAD = 2'b01,
        RUN  = 2'b10,
        REST = 2'b11
    } state_t;

    localparam logic [CW-1:0] DEAD_LOAD = CW'(DEAD_CYCLES - 1);
    localparam logic [CW-1:0] RUN_LAST  = CW'(MAX_ON - 1);
    localparam logic [CW-1:0] REST_LOAD = CW'(REST_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    state_t        state;
    logic [1:0]    target;
    logic [CW-1:0] cnt;
    logic          asp_q;
    logic          got_q;
    logic          pump_q;
    logic          busy_q;
    logic          err_q;

    logic          mode_ok_c;
    logic          stop_c;

    // Only 10 and 01 are real requests; 11 is treated as 00 for sequencing.
    assign mode_ok_c = (bus.mode == 2'b10) || (bus.mode == 2'b01);
    assign stop_c    = bus.tank_low || !mode_ok_c;

    // Output registers are loaded on the same edge as the state they decode.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            target <= 2'b00;
            cnt    <= '0;
            asp_q  <= 1'b0;
            got_q  <= 1'b0;
            pump_q <= 1'b0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (bus.mode == 2'b11) begin
                err_q <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (!stop_c) begin
                        state  <= DEAD;
                        target <= bus.mode;
                        cnt    <= DEAD_LOAD;
                        busy_q <= 1'b1;
                    end
                end

                DEAD: begin
                    if (stop_c) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (bus.mode != target) begin
                        target <= bus.mode;
                        cnt    <= DEAD_LOAD;
                    end else if (cnt == '0) begin
                        state  <= RUN;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                        pump_q <= 1'b1;
                        asp_q  <= (target == 2'b10);
                        got_q  <= (target == 2'b01);
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                RUN: begin
                    // Any exit from RUN closes both valves and the pump together.
                    if (stop_c) begin
                        state  <= IDLE;
                        asp_q  <= 1'b0;
                        got_q  <= 1'b0;
                        pump_q <= 1'b0;
                    end else if (bus.mode != target) begin
                        state  <= DEAD;
                        target <= bus.mode;
                        cnt    <= DEAD_LOAD;
                        asp_q  <= 1'b0;
                        got_q  <= 1'b0;
                        pump_q <= 1'b0;
                        busy_q <= 1'b1;
                    end else if (cnt == RUN_LAST) begin
                        state  <= REST;
                        cnt    <= REST_LOAD;
                        asp_q  <= 1'b0;
                        got_q  <= 1'b0;
                        pump_q <= 1'b0;
                        busy_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                REST: begin
                    if (cnt == '0) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                default: begin
                    state  <= IDLE;
                    asp_q  <= 1'b0;
                    got_q  <= 1'b0;
                    pump_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.valve_asp = asp_q;
    assign bus.valve_got = got_q;
    assign bus.pump      = pump_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
    assign bus.seq_state = state;

endmodule

// File: tb/tb_valve_sequencer.sv
// Scoreboard bench for valve_sequencer: directed mode/tank_low vectors queue hand-computed
// expected outputs; a negedge monitor pops and compares them.
module tb_valve_sequencer;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_DEAD = 2'b01;
    localparam logic [1:0] S_RUN  = 2'b10;
    localparam logic [1:0] S_REST = 2'b11;
    localparam logic [1:0] V_NONE = 2'b00;
    localparam logic [1:0] V_ASP  = 2'b10;
    localparam logic [1:0] V_GOT  = 2'b01;

    typedef struct {
        string      name;
        logic [6:0] val;
    } exp_t;

    logic CLK;
    logic reset;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];

    valve_sequencer_if bus ();

    valve_sequencer #(
        .DEAD_CYCLES (4),
        .MAX_ON      (10),
        .REST_CYCLES (6),
        .CW          (8)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [6:0] actual();
        return {bus.seq_state, bus.valve_asp, bus.valve_got, bus.pump, bus.busy, bus.err};
    endfunction

    task automatic check(input string nm, input logic [6:0] act, input logic [6:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {st,asp,got,pump,busy,err}=%b required %b", nm, act, exp);
        end
    endtask

    // Apply inputs, take one edge, queue what the outputs must be after that edge.
    task automatic steps(input string nm, input int n, input logic [1:0] m, input logic t,
                         input logic [1:0] st, input logic [1:0] v, input logic e);
        exp_t it;
        for (int i = 0; i < n; i++) begin
            bus.mode     = m;
            bus.tank_low = t;
            @(posedge CLK);
            it.name = nm;
            it.val  = {st, v, |v, (st == S_DEAD) || (st == S_REST), e};
            sb.push_back(it);
            #1;
        end
    endtask

    initial begin : monitor
        exp_t it;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                it = sb.pop_front();
                check(it.name, actual(), it.val);
            end
        end
    end

    initial begin : stimulus
        n_tests      = 0;
        n_fail       = 0;
        reset        = 1'b1;
        bus.mode     = 2'b00;
        bus.tank_low = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_values", actual(), 7'b0);
        @(negedge CLK);
        reset = 1'b0;

        // Power-up request: 4 dead cycles, then sprinkler; removal has one cycle latency.
        steps("t1_dead", 4, 2'b10, 1'b0, S_DEAD, V_NONE, 1'b0);
        steps("t1_run",  3, 2'b10, 1'b0, S_RUN,  V_ASP,  1'b0);
        steps("t1_off",  2, 2'b00, 1'b0, S_IDLE, V_NONE, 1'b0);

        // Drip to sprinkler switch goes through a full dead time.
        steps("t2_dead",  4, 2'b01, 1'b0, S_DEAD, V_NONE, 1'b0);
        steps("t2_run",   2, 2'b01, 1'b0, S_RUN,  V_GOT,  1'b0);
        steps("t2_sw",    1, 2'b10, 1'b0, S_DEAD, V_NONE, 1'b0);
        steps("t2_dead2", 3, 2'b10, 1'b0, S_DEAD, V_NONE, 1'b0);
        steps("t2_run2",  1, 2'b10, 1'b0, S_RUN,  V_ASP,  1'b0);
        steps("t2_off",   1, 2'b00, 1'b0, S_IDLE, V_NONE, 1'b0);

        // One-cycle tank_low aborts RUN; tank_low blocks a request in IDLE.
        steps("t3_dead",  4, 2'b10, 1'b0, S_DEAD, V_NONE, 1'b0);
        steps("t3_run",   2, 2'b10, 1'b0, S_RUN,  V_ASP,  1'b0);
        steps("t3_abort", 1, 2'b10, 1'b1, S_IDLE, V_NONE, 1'b0);
        steps("t3_block", 1, 2'b10, 1'b1, S_IDLE, V_NONE, 1'b0);
        steps("t3_idle",  1, 2'b00, 1'b0, S_IDLE, V_NONE, 1'b0);

        // Continuous drip: 10 RUN, 6 REST, 1 IDLE, 4 DEAD, RUN again.
        steps("t4_dead",  4,  2'b01, 1'b0, S_DEAD, V_NONE, 1'b0);
        steps("t4_run",   10, 2'b01, 1'b0, S_RUN,  V_GOT,  1'b0);
        steps("t4_rest",  6,  2'b01, 1'b0, S_REST, V_NONE, 1'b0);
        steps("t4_idle",  1,  2'b01, 1'b0, S_IDLE, V_NONE, 1'b0);
        steps("t4_dead2", 4,  2'b01, 1'b0, S_DEAD, V_NONE, 1'b0);
        steps("t4_run2",  2,  2'b01, 1'b0, S_RUN,  V_GOT,  1'b0);
        steps("t4_off",   1,  2'b00, 1'b0, S_IDLE, V_NONE, 1'b0);

        // Timeout coinciding with removal goes straight to IDLE.
        steps("t5_dead",   4,  2'b10, 1'b0, S_DEAD, V_NONE, 1'b0);
        steps("t5_run",    10, 2'b10, 1'b0, S_RUN,  V_ASP,  1'b0);
        steps("t5_to_off", 2,  2'b00, 1'b0, S_IDLE, V_NONE, 1'b0);

        // Timeout coinciding with a mode switch goes to DEAD, not REST.
        steps("t5b_dead",  4,  2'b10, 1'b0, S_DEAD, V_NONE, 1'b0);
        steps("t5b_run",   10, 2'b10, 1'b0, S_RUN,  V_ASP,  1'b0);
        steps("t5b_to_sw", 4,  2'b01, 1'b0, S_DEAD, V_NONE, 1'b0);
        steps("t5b_run2",  1,  2'b01, 1'b0, S_RUN,  V_GOT,  1'b0);
        steps("t5b_off",   1,  2'b00, 1'b0, S_IDLE, V_NONE, 1'b0);

        // Invalid mode sets a sticky err without opening anything.
        steps("t6_err",    1, 2'b11, 1'b0, S_IDLE, V_NONE, 1'b1);
        steps("t6_sticky", 2, 2'b00, 1'b0, S_IDLE, V_NONE, 1'b1);
        steps("t6_dead",   4, 2'b10, 1'b0, S_DEAD, V_NONE, 1'b1);
        steps("t6_run",    2, 2'b10, 1'b0, S_RUN,  V_ASP,  1'b1);

        // Asynchronous reset between edges drops everything at once.
        @(negedge CLK);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", actual(), 7'b0);
        @(posedge CLK);
        #1;
        check("reset_held", actual(), 7'b0);
        @(negedge CLK);
        reset = 1'b0;
        steps("t7_dead", 4, 2'b10, 1'b0, S_DEAD, V_NONE, 1'b0);
        steps("t7_run",  1, 2'b10, 1'b0, S_RUN,  V_ASP,  1'b0);
        steps("t7_off",  1, 2'b00, 1'b0, S_IDLE, V_NONE, 1'b0);

        repeat (4) @(negedge CLK);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/valve_sequencer.md
# valve_sequencer

Downstream actuator stage of the irrigation controller. Consumes the 2-bit irrigation mode produced by the mode state machine: 10 = sprinkler (asp), 01 = drip (got), 00 = none. Drives the two solenoid valves and the pump with break-before-make dead time, a maximum-run limit with forced rest, and a reservoir-low interlock.

## Interface
Parameters:
- DEAD_CYCLES, 4: cycles all outputs stay off before a valve opens (≥1).
- MAX_ON, 200: maximum consecutive RUN cycles before a forced rest (≥1).
- REST_CYCLES, 50: length of forced rest in cycles (≥1).
- CW, 8: counter width; all three counts must be ≤ 2^CW.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; forces the reset state immediately.
- mode  in  2  requested mode from the mode FSM; 11 is invalid and is treated as 00.
- tank_low  in  1  reservoir empty; blocks and aborts irrigation.
- valve_asp  out  1  sprinkler valve open.
- valve_got  out  1  drip valve open.
- pump  out  1  pump on.
- busy  out  1  high in DEAD or REST.
- err  out  1  sticky; set when mode==11 is sampled; cleared only by reset.
- seq_state  out  2  IDLE=00, DEAD=01, RUN=10, REST=11.

## Operation
- Registers: state, target[1:0] (latched valid mode), cnt[CW-1:0], err.
- Outputs are a Moore decode of the registered state and target. valve_asp = RUN & target==10. valve_got = RUN & target==01. pump = RUN.
- A request is valid when mode is 10 or 01 and tank_low=0.
- IDLE: if the request is valid, go to DEAD, latch target=mode, cnt=DEAD_CYCLES-1. Otherwise stay in IDLE.
- DEAD: all outputs off.
  - tank_low=1 or mode is 00/11: go to IDLE.
  - Valid mode ≠ target: re-latch target and reload cnt=DEAD_CYCLES-1; stay in DEAD.
  - cnt==0 and mode==target: go to RUN with cnt=0.
  - Otherwise decrement cnt.
- RUN, priority highest first:
  - tank_low=1 or mode is 00/11: go to IDLE.
  - Valid mode ≠ target: go to DEAD, latch the new target, cnt=DEAD_CYCLES-1. The valves are never switched directly.
  - cnt==MAX_ON-1: go to REST with cnt=REST_CYCLES-1.
  - Otherwise increment cnt.
- REST: all outputs off. mode and tank_low are ignored. At cnt==0 go to IDLE; otherwise decrement.
- At most one valve is open at any time. A valve is never open without the pump, and the pump is never on without a valve.
- err is set on any edge where mode==11 is sampled, in any state.

## Timing
- Reset values: state=IDLE, target=00, cnt=0, err=0. All outputs 0; seq_state=00.
- Reset asserted mid-RUN drops the valves and pump asynchronously, with no dead time.
- Valid request first sampled at edge E0 in IDLE: DEAD from E0, valve and pump high after edge E0+DEAD_CYCLES.
- Request removed (mode=00) sampled at edge E in RUN: outputs low after E, i.e. one cycle latency.
- Mode switch 10→01 sampled at edge E in RUN: valve_asp low after E; valve_got high after E+DEAD_CYCLES.
- Continuous request: RUN lasts exactly MAX_ON cycles, then REST lasts REST_CYCLES cycles, then IDLE for 1 cycle, then DEAD_CYCLES, then RUN again.
- A tank_low pulse of one cycle in RUN is sufficient to abort to IDLE.
- Simultaneous timeout and request removal/tank_low: go to IDLE, no rest. Simultaneous timeout and mode switch: go to DEAD, no rest.

## Test plan
- Reset then mode=10 held, defaults: seq_state 00→01 for 4 cycles; valve_asp=pump=1 from the 5th edge; valve_got=0 throughout.
- Hold mode=01 in RUN, then drive 10 for one edge: valve_got falls after that edge, 4 DEAD cycles with all outputs 0, then valve_asp=1. busy=1 only during DEAD.
- MAX_ON=10, REST_CYCLES=6, mode=01 held: valve_got high exactly 10 cycles; busy=1 and outputs 0 for 6 cycles; seq_state=00 for 1 cycle; DEAD for 4; valve_got high again.
- tank_low=1 for one cycle during RUN → outputs 0 after that edge, seq_state=00. tank_low=1 with mode=10 in IDLE → stays 00.
- mode=11 for one cycle while in IDLE → err=1, no outputs open; err stays 1 until reset; reset clears err=0.
- Assert reset asynchronously mid-RUN (between edges) → all outputs 0 immediately. After release with mode=10 held, the full 4-cycle dead time repeats.
